// File: rtl/mux_n_stream.sv
// N-channel registered stream multiplexer: explicit-select or round-robin
// channel choice feeding a single output register with valid/ready backpressure.
module mux_n_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SEL_W:0]   N_EXT     = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(N-1);

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_chan;
  logic [SEL_W-1:0]   r_rr_ptr;

  logic               w_load;
  logic               w_sel_ok;
  logic               w_rr_found;
  logic               w_req;
  logic               w_xfer;
  logic [SEL_W-1:0]   w_rr_grant;
  logic [SEL_W-1:0]   w_chan;
  logic [WIDTH-1:0]   w_data;
  logic [2*N-1:0]     w_rot;

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign w_load   = rst_n & (~r_out_valid | out_ready);
  assign w_sel_ok = ({1'b0, sel} < N_EXT);

  // Rotate valids so bit 0 is the channel at rr_ptr; first set bit wins.
  assign w_rot = {in_valid, in_valid} >> r_rr_ptr;

  always_comb begin
    logic [SEL_W:0] sum;
    w_rr_found = 1'b0;
    w_rr_grant = '0;
    sum        = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_rr_found && w_rot[k]) begin
        w_rr_found = 1'b1;
        sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
        if (sum >= N_EXT) sum = sum - N_EXT;
        w_rr_grant = sum[SEL_W-1:0];
      end
    end
  end

  assign w_chan = mode ? w_rr_grant : sel;
  assign w_req  = mode ? w_rr_found : w_sel_ok;

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = w_load & w_req & (w_chan == SEL_W'(gi));
  end

  assign w_xfer = |(in_ready & in_valid);

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_chan == SEL_W'(i)) w_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_data;
        r_out_chan <= w_chan;
        if (mode) r_rr_ptr <= (w_chan == LAST_CHAN) ? '0 : w_chan + SEL_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_n_stream.sv
// Self-checking bench for mux_n_stream: directed vector table (N=4), hand
// sequences (N=3, reset corners) and random stimulus against a reference model.
module tb_mux_n_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=4 instance
  logic        m4, or4, ov4;
  logic [1:0]  s4, oc4;
  logic [31:0] d4;
  logic [3:0]  v4, r4;
  logic [7:0]  od4;
  // N=3 instance
  logic        m3, or3, ov3;
  logic [1:0]  s3, oc3;
  logic [23:0] d3;
  logic [2:0]  v3, r3;
  logic [7:0]  od3;

  mux_n_stream #(.WIDTH(8), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(m4), .sel(s4), .in_data(d4), .in_valid(v4),
    .in_ready(r4), .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(or4));

  mux_n_stream #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(m3), .sel(s3), .in_data(d3), .in_valid(v3),
    .in_ready(r3), .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(or3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic mo, logic [1:0] se, logic [3:0] va, logic [31:0] da,
                              logic orr, logic [3:0] er, logic eov, logic [7:0] eod,
                              logic [1:0] eoc);
    vec_t v;
    v.mode = mo; v.sel = se; v.valid = va; v.data = da; v.oready = orr;
    v.exp_ready = er; v.exp_ov = eov; v.exp_od = eod; v.exp_oc = eoc;
    return v;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cyc4(input string nm, input vec_t v);
    m4 = v.mode; s4 = v.sel; v4 = v.valid; d4 = v.data; or4 = v.oready;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(r4), 32'(v.exp_ready));
    @(posedge clk); #1;
    chk({nm, "_ovalid"}, 32'(ov4), 32'(v.exp_ov));
    chk({nm, "_odata"}, 32'(od4), 32'(v.exp_od));
    chk({nm, "_ochan"}, 32'(oc4), 32'(v.exp_oc));
    $display("%s: ready=%b out_valid=%0d out_data=%02h out_chan=%0d", nm, v.exp_ready, ov4, od4, oc4);
  endtask

  task automatic cyc3(input string nm, input logic mo, input logic [1:0] se, input logic [2:0] va,
                      input logic [2:0] er, input logic eov, input logic [7:0] eod,
                      input logic [1:0] eoc);
    m3 = mo; s3 = se; v3 = va; d3 = 24'hC2B1A0; or3 = 1'b1;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(r3), 32'(er));
    @(posedge clk); #1;
    chk({nm, "_ovalid"}, 32'(ov3), 32'(eov));
    chk({nm, "_odata"}, 32'(od3), 32'(eod));
    chk({nm, "_ochan"}, 32'(oc3), 32'(eoc));
    $display("%s: ready=%b out_valid=%0d out_data=%02h out_chan=%0d", nm, r3, ov3, od3, oc3);
  endtask

  task automatic idle_inputs();
    v4 = '0; v3 = '0; m4 = 1'b0; m3 = 1'b0; s4 = '0; s3 = '0;
    d4 = '0; d3 = '0; or4 = 1'b1; or3 = 1'b1;
  endtask

  // Leaves the bench at posedge+1 with both DUTs freshly reset.
  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reference model state for the N=4 instance.
  logic       mdl_v;
  logic [7:0] mdl_d;
  int         mdl_c;
  int         mdl_p;

  task automatic rand_cycle(input int n);
    logic       load;
    logic [3:0] exp_r;
    int         g;
    m4 = 1'($urandom_range(0, 1));
    s4 = 2'($urandom_range(0, 3));
    v4 = 4'($urandom);
    d4 = $urandom;
    or4 = ($urandom_range(0, 9) < 7);
    load = !mdl_v || or4;
    g = -1;
    if (load) begin
      if (m4 == 1'b0) g = int'(s4);
      else begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (mdl_p + k) % 4;
          if (g < 0 && v4[c]) g = c;
        end
      end
    end
    exp_r = '0;
    if (g >= 0) exp_r[g] = 1'b1;
    @(negedge clk);
    chk("rand_ready", 32'(r4), 32'(exp_r));
    if (load) begin
      if (g >= 0 && v4[g]) begin
        mdl_v = 1'b1;
        mdl_d = d4[g*8 +: 8];
        mdl_c = g;
        if (m4) mdl_p = (g + 1) % 4;
      end else begin
        mdl_v = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("rand_ovalid", 32'(ov4), 32'(mdl_v));
    chk("rand_odata", 32'(od4), 32'(mdl_d));
    chk("rand_ochan", 32'(oc4), 32'(mdl_c));
    $display("rand %0d: mode=%0d sel=%0d valid=%b oready=%0d ready=%b out=%0d/%02h/%0d",
             n, m4, s4, v4, or4, r4, ov4, od4, oc4);
  endtask

  initial begin
    // Reset held with every channel valid in round-robin mode.
    rst_n = 1'b0;
    idle_inputs();
    m4 = 1'b1; v4 = 4'hF; d4 = 32'h43322110;
    m3 = 1'b1; v3 = 3'h7; d3 = 24'hC2B1A0;
    @(negedge clk);
    chk("rst_ovalid4", 32'(ov4), 32'd0);
    chk("rst_odata4", 32'(od4), 32'd0);
    chk("rst_ochan4", 32'(oc4), 32'd0);
    chk("rst_ready4", 32'(r4), 32'd0);
    chk("rst_ovalid3", 32'(ov3), 32'd0);
    chk("rst_ready3", 32'(r3), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_ready4", 32'(r4), 32'h1);
    chk("rel_ready3", 32'(r3), 32'h1);
    @(posedge clk); #1;
    chk("rel_ochan4", 32'(oc4), 32'd0);
    chk("rel_ovalid4", 32'(ov4), 32'd1);
    chk("rel_odata4", 32'(od4), 32'h10);
    $display("reset: first round-robin grant chan=%0d", oc4);

    // Directed N=4 vectors: streaming, backpressure, round-robin fairness.
    tbl[0]  = mk(0, 2, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2);
    tbl[1]  = mk(0, 2, 4'b0100, 32'h00010000, 1, 4'b0100, 1, 8'h01, 2);
    tbl[2]  = mk(0, 2, 4'b0100, 32'h00020000, 1, 4'b0100, 1, 8'h02, 2);
    tbl[3]  = mk(0, 2, 4'b0100, 32'h00030000, 1, 4'b0100, 1, 8'h03, 2);
    tbl[4]  = mk(0, 2, 4'b0000, 32'h00000000, 1, 4'b0100, 0, 8'h03, 2);
    tbl[5]  = mk(0, 1, 4'b0010, 32'h00003C00, 1, 4'b0010, 1, 8'h3C, 1);
    tbl[6]  = mk(0, 1, 4'b0010, 32'h00007700, 0, 4'b0000, 1, 8'h3C, 1);
    tbl[7]  = mk(0, 1, 4'b0010, 32'h00007700, 0, 4'b0000, 1, 8'h3C, 1);
    tbl[8]  = mk(0, 1, 4'b0010, 32'h00007700, 0, 4'b0000, 1, 8'h3C, 1);
    tbl[9]  = mk(0, 1, 4'b0010, 32'h00007700, 1, 4'b0010, 1, 8'h77, 1);
    tbl[10] = mk(0, 0, 4'b0000, 32'h00000000, 1, 4'b0001, 0, 8'h77, 1);
    tbl[11] = mk(1, 0, 4'b1111, 32'h43322110, 1, 4'b0001, 1, 8'h10, 0);
    tbl[12] = mk(1, 0, 4'b1111, 32'h43322110, 1, 4'b0010, 1, 8'h21, 1);
    tbl[13] = mk(1, 0, 4'b1111, 32'h43322110, 1, 4'b0100, 1, 8'h32, 2);
    tbl[14] = mk(1, 0, 4'b1111, 32'h43322110, 1, 4'b1000, 1, 8'h43, 3);
    tbl[15] = mk(1, 0, 4'b1111, 32'h43322110, 1, 4'b0001, 1, 8'h10, 0);
    tbl[16] = mk(1, 0, 4'b1111, 32'h43322110, 1, 4'b0010, 1, 8'h21, 1);
    tbl[17] = mk(1, 0, 4'b1010, 32'h43322110, 1, 4'b1000, 1, 8'h43, 3);
    tbl[18] = mk(1, 0, 4'b1010, 32'h43322110, 1, 4'b0010, 1, 8'h21, 1);
    tbl[19] = mk(1, 0, 4'b1010, 32'h43322110, 1, 4'b1000, 1, 8'h43, 3);
    tbl[20] = mk(1, 0, 4'b1010, 32'h43322110, 1, 4'b0010, 1, 8'h21, 1);
    tbl[21] = mk(1, 0, 4'b0000, 32'h43322110, 1, 4'b0000, 0, 8'h21, 1);
    tbl[22] = mk(1, 0, 4'b1111, 32'h43322110, 0, 4'b0100, 1, 8'h32, 2);
    tbl[23] = mk(1, 0, 4'b1111, 32'h43322110, 0, 4'b0000, 1, 8'h32, 2);

    do_reset();
    for (int i = 0; i < 24; i++) cyc4($sformatf("vec%0d", i), tbl[i]);

    // N=3: out-of-range select and explicit wrap 2 -> 0.
    do_reset();
    cyc3("n3_sel0", 0, 2'd0, 3'b111, 3'b001, 1, 8'hA0, 0);
    cyc3("n3_sel3", 0, 2'd3, 3'b111, 3'b000, 0, 8'hA0, 0);
    cyc3("n3_rr0",  1, 2'd3, 3'b111, 3'b001, 1, 8'hA0, 0);
    cyc3("n3_rr1",  1, 2'd3, 3'b111, 3'b010, 1, 8'hB1, 1);
    cyc3("n3_rr2",  1, 2'd3, 3'b111, 3'b100, 1, 8'hC2, 2);
    cyc3("n3_rr3",  1, 2'd3, 3'b111, 3'b001, 1, 8'hA0, 0);

    // Random traffic against the reference model.
    do_reset();
    mdl_v = 1'b0; mdl_d = '0; mdl_c = 0; mdl_p = 0;
    for (int n = 0; n < 300; n++) rand_cycle(n);

    // Asynchronous reset between clock edges while a beat is held.
    m4 = 1'b1; v4 = 4'hF; d4 = 32'h43322110; or4 = 1'b1;
    @(posedge clk); #1;
    chk("ares_pre_ovalid", 32'(ov4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ares_ovalid", 32'(ov4), 32'd0);
    chk("ares_odata", 32'(od4), 32'd0);
    chk("ares_ochan", 32'(oc4), 32'd0);
    chk("ares_ready", 32'(r4), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    #1;
    chk("ares_rel_ready", 32'(r4), 32'h1);
    @(posedge clk); #1;
    chk("ares_rel_ochan", 32'(oc4), 32'd0);
    chk("ares_rel_ovalid", 32'(ov4), 32'd1);
    $display("async reset: restart grant chan=%0d", oc4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_stream.md
Name: mux_n_stream

Overview:
- N-channel, WIDTH-bit registered multiplexer with valid/ready handshake per channel.
- Parametrised successor to the team's 2:1 combinational WIDTH-bit mux.
- Adds channel count N, two select modes (explicit select or round-robin arbitration), and a one-stage output register with backpressure.
- Feeds ALU operand/result paths where several producers share one consumer.

Parameters:
- WIDTH, 8, data width per channel in bits
- N, 4, number of input channels (2..16)
- SEL_W, $clog2(N), select / channel-index width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration
- sel  input  SEL_W  channel index used when mode=0
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel data valid
- in_ready  output  N  per-channel accept (combinational)
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (async assert, sync-to-clk release):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer rr_ptr=0, so channel 0 has top priority first.
- Load condition: load = ~out_valid | out_ready. The output register can take a new beat when it is empty or being drained in the same cycle.
- Throughput and latency:
  - Full throughput: one beat per cycle.
  - Latency: 1 cycle from in_valid&in_ready to out_valid.
- Transfer rules:
  - A transfer on channel i occurs when in_valid[i] & in_ready[i] at the rising edge.
  - On a transfer: out_data <= data[i], out_chan <= i, out_valid <= 1.
  - If load and no transfer: out_valid <= 0 (out_data and out_chan hold).
  - If ~load: all registers hold. out_data and out_chan must stay stable while out_valid & ~out_ready.
- Mode 0 (explicit select):
  - in_ready[sel] = load when sel < N; all other in_ready = 0.
  - sel >= N: all in_ready = 0, no transfer. This is not an error.
  - rr_ptr is not updated in mode 0.
- Mode 1 (round-robin):
  - Grant goes to the first channel with in_valid set, scanning from rr_ptr upward and wrapping N-1 -> 0.
  - in_ready[g] = load for the granted channel g only. in_ready is never asserted for a channel whose in_valid is 0.
  - No valid channel: all in_ready = 0.
  - On a transfer from channel g: rr_ptr <= (g+1) mod N. If N is not a power of 2, the wrap is explicit (N-1 -> 0).
- At most one in_ready bit is high in any cycle (one-hot or zero), in both modes.
- Mode or sel change takes effect in the same cycle, combinationally. An already-registered beat is unaffected.
- A producer may drop in_valid without a transfer. No channel state is kept.
- Reset asserted mid-transfer: the beat is discarded and all outputs return to reset values immediately.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0; after release, first mode=1 grant goes to channel 0.
- Mode 0 streaming: WIDTH=8, N=4, sel=2, in_data ch2=0xA5 valid, out_ready=1 -> next cycle out_data=0xA5, out_chan=2; back-to-back beats 0x01,0x02,0x03 appear on consecutive cycles.
- Backpressure: out_valid=1 with 0x3C, out_ready=0 for 3 cycles, ch1 valid with 0x77 -> out_data stays 0x3C, in_ready=0; out_ready=1 -> ch1 accepted, 0x77 appears next cycle.
- Round-robin fairness: mode=1, all 4 channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1; with only ch1 and ch3 valid -> 1,3,1,3.
- Out-of-range select and non-power-of-2 N: N=3, sel=3 -> in_ready=000, out_valid falls to 0; mode=1 with all valid -> out_chan 0,1,2,0 (wrap at 2).
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> outputs clear without a clock edge; rr_ptr restarts at 0.
